// File: rtl/riscv_dp_wb_ctrl.sv
// rtl/riscv_dp_wb_ctrl.sv - register-file write-back arbiter with long-latency busy scoreboard
//
// Purpose: sole writer of the register-file write port. Merges results from the
// in-order pipeline (A, no backpressure) and a long-latency unit (B, valid/ready)
// through a one-entry hold buffer, and tracks which destinations still await a
// long-latency result so decode can stall dependent instructions.
//
// Ports:
//   iclk, irst                     clock (rising edge), async active-high reset
//   ia_valid/ia_addr/ia_data       pipeline result; oa_stall forbids ia_valid
//   ib_valid/ib_addr/ib_data       long-latency result; ob_ready accepts it
//   iissue_valid/iissue_addr       long-latency issue, marks destination busy
//   iq_addr1/2 -> oq_busy1/2       combinational scoreboard queries
//   owr_en3/owr_addr3/owr_data3    registered regfile write port
//   oerr_drop                      sticky flag: an A result was dropped
module riscv_dp_wb_ctrl #(
    parameter int MP_DATA_WIDTH   = 32,
    parameter int MP_ADDR_WIDTH   = 5,
    parameter int MP_STARVE_LIMIT = 4
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ia_valid,
    input  logic [MP_ADDR_WIDTH-1:0] ia_addr,
    input  logic [MP_DATA_WIDTH-1:0] ia_data,
    output logic                     oa_stall,
    input  logic                     ib_valid,
    output logic                     ob_ready,
    input  logic [MP_ADDR_WIDTH-1:0] ib_addr,
    input  logic [MP_DATA_WIDTH-1:0] ib_data,
    input  logic                     iissue_valid,
    input  logic [MP_ADDR_WIDTH-1:0] iissue_addr,
    input  logic [MP_ADDR_WIDTH-1:0] iq_addr1,
    output logic                     oq_busy1,
    input  logic [MP_ADDR_WIDTH-1:0] iq_addr2,
    output logic                     oq_busy2,
    output logic                     owr_en3,
    output logic [MP_ADDR_WIDTH-1:0] owr_addr3,
    output logic [MP_DATA_WIDTH-1:0] owr_data3,
    output logic                     oerr_drop
);

    localparam int         NREG  = 1 << MP_ADDR_WIDTH;
    localparam logic [3:0] LIMIT = 4'(MP_STARVE_LIMIT);

    logic                     hold_valid;
    logic [MP_ADDR_WIDTH-1:0] hold_addr;
    logic [MP_DATA_WIDTH-1:0] hold_data;
    logic [3:0]               age;
    logic [NREG-1:0]          busy;
    logic [NREG-1:0]          busy_next;

    logic a_live;
    logic drain;
    logic commit_a;
    logic take_b;

    // A to x0 is a no-op and must not steal the write slot from the hold.
    assign a_live   = ia_valid & (ia_addr != '0);
    assign oa_stall = hold_valid & (age == LIMIT);
    // A starved hold wins even over live A traffic; otherwise A has priority.
    assign drain    = hold_valid & (oa_stall | ~a_live);
    assign commit_a = a_live & ~oa_stall;
    // Ready depends only on registered state so B never sees a comb loop.
    assign ob_ready = ~irst & ~hold_valid;
    assign take_b   = ib_valid & ob_ready;

    assign oq_busy1 = busy[iq_addr1];
    assign oq_busy2 = busy[iq_addr2];

    // Issue is applied after the drain clear so a same-cycle re-issue keeps the bit set.
    always_comb begin
        busy_next = busy;
        if (drain) begin
            busy_next[hold_addr] = 1'b0;
        end
        if (iissue_valid) begin
            busy_next[iissue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            age        <= 4'd0;
            busy       <= '0;
            owr_en3    <= 1'b0;
            owr_addr3  <= '0;
            owr_data3  <= '0;
            oerr_drop  <= 1'b0;
        end else begin
            busy <= busy_next;

            if (oa_stall && ia_valid) begin
                oerr_drop <= 1'b1;
            end

            if (drain) begin
                owr_en3   <= (hold_addr != '0);
                owr_addr3 <= hold_addr;
                owr_data3 <= hold_data;
            end else if (commit_a) begin
                owr_en3   <= 1'b1;
                owr_addr3 <= ia_addr;
                owr_data3 <= ia_data;
            end else begin
                owr_en3   <= 1'b0;
            end

            if (drain) begin
                hold_valid <= 1'b0;
                age        <= 4'd0;
            end else if (take_b) begin
                hold_valid <= 1'b1;
                hold_addr  <= ib_addr;
                hold_data  <= ib_data;
                age        <= 4'd0;
            end else if (hold_valid && (age != LIMIT)) begin
                age <= age + 4'd1;
            end
        end
    end

endmodule

// File: doc/riscv_dp_wb_ctrl.md
Name: riscv_dp_wb_ctrl

Overview:
Write-back controller that owns the register-file write port: the single writer feeding the regfile's iaddr3/iwr_en3/iwr_data3.
- Merges two result sources:
  - The in-order pipeline (source A), which has no backpressure.
  - A long-latency unit (source B, e.g. load or divide), using a valid/ready handshake.
- Keeps a busy scoreboard of outstanding long-latency destinations; decode queries it to stall dependent instructions.

Parameters:
MP_DATA_WIDTH, 32, register data width
MP_ADDR_WIDTH, 5, register index width; 2**MP_ADDR_WIDTH registers
MP_STARVE_LIMIT, 4, cycles a buffered B result may wait before source A is stalled (range 1..15)

Ports:
iclk  in  1  clock, rising edge
irst  in  1  asynchronous active-high reset
ia_valid  in  1  pipeline result valid this cycle
ia_addr  in  MP_ADDR_WIDTH  pipeline destination register
ia_data  in  MP_DATA_WIDTH  pipeline result
oa_stall  out  1  pipeline must not present ia_valid while high
ib_valid  in  1  long-latency result valid
ob_ready  out  1  long-latency result accepted when ib_valid & ob_ready
ib_addr  in  MP_ADDR_WIDTH  long-latency destination register
ib_data  in  MP_DATA_WIDTH  long-latency result
iissue_valid  in  1  long-latency op issued; mark destination busy
iissue_addr  in  MP_ADDR_WIDTH  destination of issued op
iq_addr1  in  MP_ADDR_WIDTH  scoreboard query 1
oq_busy1  out  1  register iq_addr1 has a pending long-latency write
iq_addr2  in  MP_ADDR_WIDTH  scoreboard query 2
oq_busy2  out  1  register iq_addr2 has a pending long-latency write
owr_en3  out  1  regfile write enable (registered)
owr_addr3  out  MP_ADDR_WIDTH  regfile write address (registered)
owr_data3  out  MP_DATA_WIDTH  regfile write data (registered)
oerr_drop  out  1  sticky: an A result was dropped (protocol violation)

Behaviour:
- Reset (async, immediate):
  - owr_en3=0, owr_addr3=0, owr_data3=0.
  - Hold buffer empty, age counter 0, all busy bits 0, oerr_drop=0.
  - During reset: ob_ready=0, oa_stall=0.
- Hold buffer: one entry (valid, addr, data).
  - ob_ready = ~irst & ~hold_valid. This is a registered-state function and never depends on ib_valid.
  - On a handshake, B is captured at the edge and hold_valid is set.
- Age counter: increments each cycle hold_valid is set and the hold is not drained, saturating at MP_STARVE_LIMIT. Cleared on drain.
  - oa_stall = hold_valid & (age == MP_STARVE_LIMIT).
- Write selection, per cycle. Outputs appear on owr_* one cycle later:
  1. If oa_stall & hold_valid: commit the hold.
     - If ia_valid is also high, A is dropped and oerr_drop is set.
  2. Else if ia_valid & ia_addr!=0: commit A. The hold is kept and ages.
  3. Else if hold_valid: commit the hold.
  4. Else: owr_en3=0 next cycle.
- Committing the hold: owr_en3 = (hold_addr!=0); hold_valid is cleared; busy[hold_addr] is cleared at the same edge.
  - A new B may be accepted the cycle after the drain, because ob_ready rises then.
- x0 rules:
  - A to x0 produces no write and does not block the hold.
  - B to x0 is accepted and drained without a write.
  - Issue to x0 is ignored.
  - busy[0] is hardwired 0.
- Scoreboard updates:
  - The busy bit is set on iissue_valid at the edge.
  - Set and clear of the same address in one cycle: set wins, because a new op was issued.
  - Issue to an already-busy register leaves it busy. Decode guarantees at most one outstanding op per register.
  - A commits never touch busy bits.
  - WAW ordering between A and B is upstream's responsibility: decode never issues A to a busy destination.
- Queries are combinational from the busy register: oq_busyN = busy[iq_addrN]. A clear takes effect the cycle after the commit edge, the same cycle the regfile receives the write. Decode uses the regfile's combinational read of owr_* via its own bypass.
- Latency:
  - A: 1 cycle from ia_valid to owr_en3.
  - B: at least 2 cycles (capture, then commit).
  - B: worst case MP_STARVE_LIMIT+2 cycles under continuous A traffic.

Test Plan:
- Reset mid-operation: hold valid, busy[7]=1, assert irst asynchronously -> owr_en3=0, ob_ready=0, busy cleared immediately; after release ob_ready=1.
- A only: ia_valid, addr=5, data=0xDEADBEEF -> next cycle owr_en3=1, owr_addr3=5, owr_data3=0xDEADBEEF. Same with addr=0 -> owr_en3 stays 0.
- B round-trip: issue addr=9 -> oq_busy1(9)=1. B handshake addr=9, data=0x1234 with A idle -> owr at +2 cycles, oq_busy1(9)=0 the following cycle, ob_ready back to 1.
- Contention: A continuous to addr=3 while B holds addr=12, limit=4 -> hold waits 4 cycles, then oa_stall=1 for one cycle, B commits, oa_stall=0. A kept valid during stall -> oerr_drop=1.
- Simultaneous set/clear: hold for addr=4 commits in the same cycle iissue_addr=4 -> busy[4] remains 1. Issue to x0 -> oq_busy(0)=0.
- Backpressure: ib_valid held while hold full -> no second capture; ib_data changes are ignored until ob_ready=1.
